lfsr_rng: RTL and testbench
===========================

LFSR_RNG -- requirements
Module: lfsr_rng

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning LFSR state width (3..32).
REQ-002 The block SHALL have parameter TAPS [WIDTH-1:0], default 16'hB400, meaning a feedback tap mask where bit i set selects state[i].
REQ-003 The block SHALL have parameter SEED [WIDTH-1:0], default all-ones, meaning the reset and lockup-recovery state; it SHALL be non-zero.
REQ-004 The block SHALL have parameter RANGE, default 4, meaning draw values lie in 0..RANGE-1 (2 <= RANGE <= 2^WIDTH); OUT_W = max(1, clog2(RANGE)).
REQ-005 The block SHALL have parameter MAX_TRIES, default 4, meaning the rejection attempts before forced fold (>= 1).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rstn, input, 1 bit: synchronous, active-low reset.
REQ-008 The block SHALL have port en, input, 1 bit: free-run advance enable.
REQ-009 The block SHALL have ports seed_load, input, 1 bit, and seed_in, input, WIDTH bits: load seed_in into the state.
REQ-010 The block SHALL have ports req, input, 1 bit, and ready, output, 1 bit: draw request handshake.
REQ-011 The block SHALL have ports valid, output, 1 bit, and value, output, OUT_W bits: draw result, valid as a one-cycle pulse.
REQ-012 The block SHALL have port state, output, WIDTH bits: raw LFSR state.

Function
REQ-013 Advance SHALL be Fibonacci: next = {state[WIDTH-2:0], ^(state & TAPS)}.
REQ-014 State SHALL advance when en=1 or the FSM is in DRAW, and never more than one step per cycle.
REQ-015 seed_load SHALL take priority over advance: state <= seed_in, or SEED if seed_in == 0; a draw in progress SHALL continue from the loaded state.
REQ-016 If state is ever zero, the next state SHALL be SEED (lockup recovery).
REQ-017 The FSM SHALL have states IDLE and DRAW; ready = 1 only in IDLE; a request is accepted when req & ready, giving IDLE -> DRAW.
REQ-018 In DRAW, each cycle: candidate = state[OUT_W-1:0], tries increments, and state advances.
REQ-019 If candidate < RANGE: value <= candidate, valid <= 1 next cycle, and the FSM returns to IDLE.
REQ-020 If candidate >= RANGE and tries == MAX_TRIES: value <= candidate - RANGE, valid <= 1 next cycle, and the FSM returns to IDLE.
REQ-021 Otherwise the FSM SHALL remain in DRAW.
REQ-022 Minimum latency SHALL be 2 cycles from accepted req to valid, and maximum SHALL be MAX_TRIES+1 cycles.
REQ-023 Back-to-back draws SHALL be accepted in the valid cycle, since the FSM is already in IDLE.
REQ-024 If RANGE is a power of two, no rejection SHALL occur and latency SHALL be exactly 2.
REQ-025 value SHALL hold its last result between draws; valid SHALL be high for exactly one cycle per accepted req.
REQ-026 req while ready = 0 SHALL be ignored, not queued.

Reset
REQ-027 On rstn = 0 at a clock edge: state = SEED, FSM = IDLE, tries = 0, valid = 0, value = 0, ready = 1 the following cycle.
REQ-028 Reset mid-draw SHALL abandon the draw without producing a valid pulse.
REQ-029 Reset SHALL override seed_load, en and req.

Structure
REQ-030 Shared package lfsr_pkg SHALL hold the FSM state enum and a table of maximal-length tap constants for WIDTH 3..32.
REQ-031 Sub-module lfsr_core SHALL hold the state register, advance, seed load and lockup recovery; lfsr_rng SHALL add the draw FSM.

Verification (WIDTH=5, TAPS=5'b10100, SEED=5'h1F, RANGE=3, MAX_TRIES=4)
REQ-032 Reset, then en=1 for 4 cycles -> state 1F, 1E, 1C, 18, 11; 31 cycles total -> state returns to 1F.
REQ-033 After reset with en=0, req pulse -> DRAW checks 1F (cand 3, reject), then 1E (cand 2, accept) -> valid at cycle 3 with value=2, state=1C.
REQ-034 seed_load=1 with seed_in=0 -> state=1F next cycle; seed_load together with en -> loaded value wins.
REQ-035 Seed chosen so that 4 candidates equal 3 -> valid after 4 DRAW cycles with value=0 (fold).
REQ-036 rstn low during DRAW -> no valid pulse, ready=1, state=1F; req held high continuously -> exactly one valid pulse per accepted draw.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random-number block.
// Holds the draw FSM state encoding and a lookup of maximal-length Fibonacci
// tap masks for state widths 3..32. In each mask, bit i set selects state[i].
package lfsr_pkg;

  localparam int unsigned MIN_WIDTH = 3;
  localparam int unsigned MAX_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } fsm_e;

  // Maximal-length tap masks for shift-left Fibonacci (feedback into bit 0).
  function automatic logic [MAX_WIDTH-1:0] max_len_taps(input int unsigned width);
    logic [MAX_WIDTH-1:0] t;
    case (width)
      3:       t = 32'h0000_0006;
      4:       t = 32'h0000_000C;
      5:       t = 32'h0000_0014;
      6:       t = 32'h0000_0030;
      7:       t = 32'h0000_0060;
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0829;
      13:      t = 32'h0000_100D;
      14:      t = 32'h0000_2015;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_D008;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0004_0023;
      20:      t = 32'h0009_0000;
      21:      t = 32'h0014_0000;
      22:      t = 32'h0030_0000;
      23:      t = 32'h0042_0000;
      24:      t = 32'h00E1_0000;
      25:      t = 32'h0120_0000;
      26:      t = 32'h0200_0023;
      27:      t = 32'h0400_0013;
      28:      t = 32'h0900_0000;
      29:      t = 32'h1400_0000;
      30:      t = 32'h2000_0029;
      31:      t = 32'h4800_0000;
      32:      t = 32'h8020_0003;
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register: Fibonacci advance, seed load and lockup recovery.
// Ports:
//   clk, rstn          clock, synchronous active-low reset (state -> SEED)
//   adv_i              advance one step this cycle
//   load_i, load_val_i load a new seed (zero is replaced by SEED); beats adv_i
//   state_o            current LFSR state
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             adv_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  // Next state: load first, then escape from the all-zero lockup, then advance.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (load_val_i == '0) ? SEED : load_val_i;
    end else if (state_q == '0) begin
      state_d = SEED;
    end else if (adv_i) begin
      state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/lfsr_rng.sv
// Random draw engine: LFSR core plus a rejection-sampling FSM producing
// values uniformly-ish in 0..RANGE-1.
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   en                 free-run advance of the LFSR
//   seed_load, seed_in load seed_in into the LFSR (zero maps to SEED)
//   req, ready         draw request handshake; accepted on req & ready
//   valid, value       one-cycle result pulse; value holds between draws
//   state              raw LFSR state
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
  parameter logic [WIDTH-1:0] SEED      = '1,
  parameter longint unsigned  RANGE     = 4,
  parameter int unsigned      MAX_TRIES = 4,
  localparam int unsigned     OUT_W     = ($clog2(RANGE) > 1) ? $clog2(RANGE) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic             ready,
  output logic             valid,
  output logic [OUT_W-1:0] value,
  output logic [WIDTH-1:0] state
);

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

  fsm_e             fsm_q, fsm_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] value_q, value_d;
  logic             ready_q;
  logic [OUT_W-1:0] cand;
  logic             adv;

  assign adv  = en | (fsm_q == DRAW);
  assign cand = state[OUT_W-1:0];

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk        (clk),
    .rstn       (rstn),
    .adv_i      (adv),
    .load_i     (seed_load),
    .load_val_i (seed_in),
    .state_o    (state)
  );

  // Draw FSM. tries_d counts the attempt being made this cycle, so the
  // MAX_TRIES-th rejected candidate is folded instead of retried.
  always_comb begin
    fsm_d   = fsm_q;
    tries_d = tries_q;
    valid_d = 1'b0;
    value_d = value_q;
    case (fsm_q)
      IDLE: begin
        if (req) begin
          fsm_d   = DRAW;
          tries_d = '0;
        end
      end
      DRAW: begin
        tries_d = tries_q + TRY_W'(1);
        if (64'(cand) < RANGE) begin
          value_d = cand;
          valid_d = 1'b1;
          fsm_d   = IDLE;
        end else if (tries_d == TRY_W'(MAX_TRIES)) begin
          // cand < 2^OUT_W < 2*RANGE, so one subtraction lands in range.
          value_d = cand - OUT_W'(RANGE);
          valid_d = 1'b1;
          fsm_d   = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fsm_q   <= IDLE;
      tries_q <= '0;
      valid_q <= 1'b0;
      value_q <= '0;
      ready_q <= 1'b1;
    end else begin
      fsm_q   <= fsm_d;
      tries_q <= tries_d;
      valid_q <= valid_d;
      value_q <= value_d;
      ready_q <= (fsm_d == IDLE);
    end
  end

  assign ready = ready_q;
  assign valid = valid_q;
  assign value = value_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng with WIDTH=5, TAPS=5'b10100, SEED=5'h1F,
// RANGE=3, MAX_TRIES=4. Expected values are hand-traced LFSR sequences.
module tb_lfsr_rng;

  localparam int unsigned W = 5;

  logic         clk;
  logic         rstn;
  logic         en;
  logic         seed_load;
  logic [W-1:0] seed_in;
  logic         req;
  logic         ready;
  logic         valid;
  logic [1:0]   value;
  logic [W-1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  lfsr_rng #(
    .WIDTH     (W),
    .TAPS      (5'b10100),
    .SEED      (5'h1F),
    .RANGE     (3),
    .MAX_TRIES (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .req       (req),
    .ready     (ready),
    .valid     (valid),
    .value     (value),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  // Held-request trace from state 1F: valid pattern and values per edge.
  localparam bit [0:11] EXP_V   = 12'b001010101001;
  localparam int        EXP_VAL [0:11] = '{0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 2};
  localparam logic [W-1:0] EXP_RUN [0:3] = '{5'h1E, 5'h1C, 5'h18, 5'h11};

  initial begin
    rstn = 1'b0; en = 1'b0; seed_load = 1'b0; seed_in = '0; req = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    check("rst_state", 32'(state), 32'h1F);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_value", 32'(value), 32'd0);

    // Free-run sequence and full period.
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("run%0d", i), 32'(state), 32'(EXP_RUN[i]));
    end
    for (int i = 0; i < 27; i++) tick();
    check("period31", 32'(state), 32'h1F);
    en = 1'b0;

    // Single draw: reject 1F (cand 3), accept 1E (cand 2).
    do_reset();
    req = 1'b1;
    tick();
    req = 1'b0;
    check("draw_busy_ready", 32'(ready), 32'd0);
    check("draw_c1_state", 32'(state), 32'h1F);
    tick();
    check("draw_c2_valid", 32'(valid), 32'd0);
    check("draw_c2_state", 32'(state), 32'h1E);
    tick();
    check("draw_c3_valid", 32'(valid), 32'd1);
    check("draw_c3_value", 32'(value), 32'd2);
    check("draw_c3_state", 32'(state), 32'h1C);
    check("draw_c3_ready", 32'(ready), 32'd1);
    tick();
    check("draw_c4_valid", 32'(valid), 32'd0);
    check("draw_hold_value", 32'(value), 32'd2);
    check("draw_idle_state", 32'(state), 32'h1C);

    // Seed load: zero maps to SEED; load beats en.
    seed_load = 1'b1; seed_in = 5'h00;
    tick();
    check("seed_zero", 32'(state), 32'h1F);
    seed_in = 5'h0A; en = 1'b1;
    tick();
    check("seed_vs_en", 32'(state), 32'h0A);
    seed_load = 1'b0; en = 1'b0;

    // Fold: seed 13 gives candidates 3,3,3,3 (states 13,07,0F,1F).
    seed_load = 1'b1; seed_in = 5'h13;
    tick();
    seed_load = 1'b0;
    check("fold_seed", 32'(state), 32'h13);
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fold_wait%0d", i), 32'(valid), 32'd0);
    end
    tick();
    check("fold_valid", 32'(valid), 32'd1);
    check("fold_value", 32'(value), 32'd0);
    check("fold_state", 32'(state), 32'h1E);

    // Reset mid-draw (req still high): draw abandoned, no pulse.
    tick();
    req = 1'b1;
    tick();
    check("mid_busy", 32'(ready), 32'd0);
    rstn = 1'b0;
    tick();
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_state", 32'(state), 32'h1F);
    check("mid_rst_value", 32'(value), 32'd0);
    tick();
    check("mid_rst_hold", 32'(valid), 32'd0);
    rstn = 1'b1;

    // Request held continuously: one pulse per accepted draw, none queued.
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("held_valid%0d", i), 32'(valid), 32'(EXP_V[i]));
      if (EXP_V[i]) check($sformatf("held_value%0d", i), 32'(value), 32'(EXP_VAL[i]));
    end
    check("held_state", 32'(state), 32'h0D);
    req = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
